multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Sequencing control unit for the multi-cycle RV32I datapath. It succeeds the single-cycle opcode decoder.
- Decodes the 7-bit opcode and steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Handshakes with a variable-latency unified memory (mem_req/mem_ready) and bounds each wait with a timeout.
- Adds JAL/JALR/LUI/AUIPC support and illegal-opcode trapping; sits between the instruction register and all datapath mux/enable controls.

Parameters:
- SUPPORT_JUMP, 1, when 1, JAL/JALR are legal; when 0, they trap as illegal.
- SUPPORT_UPPER, 1, when 1, LUI/AUIPC are legal; when 0, they trap as illegal.
- MEM_WAIT_MAX, 15, maximum cycles any memory state waits for mem_ready before trapping; range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0], taken from the instruction register.
- mem_ready  in  1  memory completes the current request this cycle.
- zero  in  1  ALU branch-condition result, already resolved for funct3.
- mem_req  out  1  memory request strobe, held high until mem_ready.
- mem_we  out  1  write request; valid only with mem_req.
- i_or_d  out  1  memory address select: 0=PC, 1=ALU result register.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- alu_src_a  out  2  ALU A select: 0=PC, 1=rs1, 2=old PC.
- alu_src_b  out  2  ALU B select: 0=rs2, 1=imm, 2=const 4.
- alu_op  out  2  ALU op: 00=add, 01=branch compare, 10=R-funct, 11=I-funct.
- imm_sel  out  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J.
- result_src  out  2  writeback source: 0=ALU result register, 1=memory data, 2=PC+4.
- reg_write  out  1  register file write enable.
- illegal_instr  out  1  sticky; undecoded opcode reached.
- mem_timeout  out  1  sticky; wait limit exceeded.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset, asynchronous: state=FETCH, wait counter=0, sticky flags=0. Every control output defaults to 0 in every state unless listed below.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=2. ir_write and pc_write are Mealy outputs, asserted only in the cycle mem_ready=1; transition to DECODE on that cycle.
- DECODE: alu_src_a=2, alu_src_b=1, imm_sel=B. This precomputes the branch target. Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 or 0010111 -> UPPER
  - anything else, or a disabled class -> TRAP with illegal_instr set.
- MEM_ADDR: alu_src_a=1, alu_src_b=1, alu_op=00, imm_sel=I for load, S for store. Go to MEM_READ for load, MEM_WRITE for store.
- MEM_READ: mem_req=1, i_or_d=1; on mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, result_src=1; go to FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, i_or_d=1; on mem_ready go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=10; go to ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=1, alu_op=11, imm_sel=I; go to ALU_WB.
- ALU_WB: reg_write=1, result_src=0; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_write_cond=1; go to FETCH.
- JAL: reg_write=1, result_src=2, pc_write=1, alu_src_a=2, alu_src_b=1, imm_sel=J; go to FETCH.
- JALR: reg_write=1, result_src=2, pc_write=1, alu_src_a=1, alu_src_b=1, imm_sel=I; go to FETCH.
- UPPER: imm_sel=U, alu_src_b=1, alu_src_a=2 for AUIPC, A forced to 0 via alu_op=00 with src_a=3 for LUI; go to ALU_WB.
- Wait counter:
  - Increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready and on any state change.
  - When counter==MEM_WAIT_MAX and mem_ready=0, next state is TRAP and mem_timeout is set.
  - mem_ready arriving in the same cycle as the limit wins; no trap.
- TRAP: absorbing state, all outputs 0, leaves only on reset. mem_req drops the cycle after entry.
- Handshake rules: mem_req, mem_we and i_or_d stay stable from assertion until mem_ready. mem_ready while mem_req=0 is ignored.
- Reset mid-request: mem_req drops asynchronously; the memory must discard the request.

Decomposition:
- Package rv_ctrl_pkg holds:
  - the state_t enum (4-bit, encodings fixed for state_o)
  - opcode localparams
  - alu_op, imm_sel, alu_src_a/b and result_src encodings, shared with the datapath muxes and the immediate generator.
- Sub-module mem_wait_timer: 8-bit counter with clear/enable and expired compare against MEM_WAIT_MAX.

Test Plan:
- Add, opcode=0110011, mem_ready on 1st cycle: states FETCH,DECODE,EXEC_R,ALU_WB; reg_write=1 only in cycle 4; 4 cycles total.
- Load, opcode=0000011, mem_ready 3 cycles late in both FETCH and MEM_READ: mem_req held steady throughout; reg_write with result_src=1 in MEM_WB; no timeout.
- Store with MEM_WAIT_MAX=4, mem_ready never asserted in MEM_WRITE: after 4 wait cycles, state=TRAP, mem_timeout=1, mem_req=0 on the following cycle.
- Timeout boundary: mem_ready on the exact limit cycle: no trap, FETCH reached.
- Illegal opcode 1111111 (and 1101111 with SUPPORT_JUMP=0): DECODE to TRAP, illegal_instr=1 and held until reset; reset returns to FETCH with flags cleared.
- Branch, opcode=1100011, zero=1 then zero=0: pc_write_cond=1 in BRANCH both times, pc_write=0. JAL: pc_write=1, reg_write=1, result_src=2 in the same cycle.
- Reset asserted mid-MEM_READ: all outputs 0 asynchronously; FETCH on release.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit, datapath muxes and immediate generator.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_UPPER     = 4'd12,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_RS1    = 2'd1;
  localparam logic [1:0] SRCA_OLDPC  = 2'd2;
  localparam logic [1:0] SRCA_ZERO   = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_sel;
    logic [1:0] result_src;
    logic       reg_write;
  } ctl_t;

  // Disabled instruction classes decode exactly like unknown opcodes.
  function automatic state_t decode_next(input logic [6:0] op, input logic jump_en,
                                         input logic upper_en);
    state_t nxt;
    case (op)
      OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
      OP_R:              nxt = S_EXEC_R;
      OP_I:              nxt = S_EXEC_I;
      OP_BRANCH:         nxt = S_BRANCH;
      OP_JAL:            nxt = jump_en ? S_JAL : S_TRAP;
      OP_JALR:           nxt = jump_en ? S_JALR : S_TRAP;
      OP_LUI, OP_AUIPC:  nxt = upper_en ? S_UPPER : S_TRAP;
      default:           nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; expired_o flags that the wait limit has been reached.
module mem_wait_timer #(
  parameter int unsigned MAX = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == 8'(MAX));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: steps each instruction through its states, drives all datapath
// controls, handshakes with unified memory and traps on illegal opcodes or memory timeouts.
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter bit          SUPPORT_JUMP  = 1'b1,
  parameter bit          SUPPORT_UPPER = 1'b1,
  parameter int unsigned MEM_WAIT_MAX  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_sel,
  output logic [1:0] result_src,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   timeout_q, timeout_d;
  logic   wait_expired;
  ctl_t   ctl;

  // The branch condition is consumed by the PC write gating in the datapath.
  logic   unused_zero;
  assign unused_zero = zero;

  mem_wait_timer #(.MAX(MEM_WAIT_MAX)) u_wait_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .clr_i     (mem_ready || (state_d != state_q)),
    .en_i      (ctl.mem_req && !mem_ready),
    .expired_o (wait_expired)
  );

  always_comb begin
    ctl       = '0;
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_a = SRCA_PC;
        ctl.alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_sel   = IMM_B;
        state_d       = decode_next(opcode, SUPPORT_JUMP, SUPPORT_UPPER);
        if (state_d == S_TRAP) illegal_d = 1'b1;
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
        ctl.imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d       = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctl.mem_req = 1'b1;
        ctl.i_or_d  = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.result_src = RES_MEM;
        state_d        = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = 1'b1;
        ctl.i_or_d  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_RS2;
        ctl.alu_op    = ALU_RFUNCT;
        state_d       = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_IFUNCT;
        ctl.imm_sel   = IMM_I;
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.result_src = RES_ALU;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = SRCA_RS1;
        ctl.alu_src_b     = SRCB_RS2;
        ctl.alu_op        = ALU_BRANCH;
        ctl.pc_write_cond = 1'b1;
        state_d           = S_FETCH;
      end
      S_JAL: begin
        ctl.reg_write  = 1'b1;
        ctl.result_src = RES_PC4;
        ctl.pc_write   = 1'b1;
        ctl.alu_src_a  = SRCA_OLDPC;
        ctl.alu_src_b  = SRCB_IMM;
        ctl.imm_sel    = IMM_J;
        state_d        = S_FETCH;
      end
      S_JALR: begin
        ctl.reg_write  = 1'b1;
        ctl.result_src = RES_PC4;
        ctl.pc_write   = 1'b1;
        ctl.alu_src_a  = SRCA_RS1;
        ctl.alu_src_b  = SRCB_IMM;
        ctl.imm_sel    = IMM_I;
        state_d        = S_FETCH;
      end
      S_UPPER: begin
        // LUI adds the immediate to a forced-zero A operand.
        ctl.imm_sel   = IMM_U;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
        ctl.alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        state_d       = S_ALU_WB;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    // A ready on the limit cycle completes the access instead of trapping.
    if (ctl.mem_req && !mem_ready && wait_expired) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end

    // Controls drop with reset itself so a pending memory request is withdrawn at once.
    if (reset) ctl = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_req       = ctl.mem_req;
  assign mem_we        = ctl.mem_we;
  assign i_or_d        = ctl.i_or_d;
  assign ir_write      = ctl.ir_write;
  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign imm_sel       = ctl.imm_sel;
  assign result_src    = ctl.result_src;
  assign reg_write     = ctl.reg_write;
  assign illegal_instr = illegal_q;
  assign mem_timeout   = timeout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected control vectors go through a queue.
module tb_multicycle_control_fsm;
  import rv_ctrl_pkg::*;

  logic       clk, reset, mem_ready, zero;
  logic [6:0] opcode;

  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write;
  logic       illegal_instr, mem_timeout;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_sel;
  logic [3:0] state_o;

  logic       nj_mem_req, nj_mem_we, nj_i_or_d, nj_ir_write, nj_pc_write, nj_pc_write_cond;
  logic       nj_reg_write, nj_illegal_instr, nj_mem_timeout;
  logic [1:0] nj_alu_src_a, nj_alu_src_b, nj_alu_op, nj_result_src;
  logic [2:0] nj_imm_sel;
  logic [3:0] nj_state_o;

  logic [23:0] exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic        ill_exp = 1'b0;
  logic        to_exp = 1'b0;

  wire [23:0] obs = {state_o, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                     alu_src_a, alu_src_b, alu_op, imm_sel, result_src, reg_write,
                     illegal_instr, mem_timeout};
  wire [23:0] nj_obs = {nj_state_o, nj_mem_req, nj_mem_we, nj_i_or_d, nj_ir_write, nj_pc_write,
                        nj_pc_write_cond, nj_alu_src_a, nj_alu_src_b, nj_alu_op, nj_imm_sel,
                        nj_result_src, nj_reg_write, nj_illegal_instr, nj_mem_timeout};

  multicycle_control_fsm #(.SUPPORT_JUMP(1'b1), .SUPPORT_UPPER(1'b1), .MEM_WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .result_src(result_src),
    .reg_write(reg_write), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout),
    .state_o(state_o)
  );

  multicycle_control_fsm #(.SUPPORT_JUMP(1'b0), .SUPPORT_UPPER(1'b0), .MEM_WAIT_MAX(15)) dut_nj (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .mem_req(nj_mem_req), .mem_we(nj_mem_we), .i_or_d(nj_i_or_d), .ir_write(nj_ir_write),
    .pc_write(nj_pc_write), .pc_write_cond(nj_pc_write_cond), .alu_src_a(nj_alu_src_a),
    .alu_src_b(nj_alu_src_b), .alu_op(nj_alu_op), .imm_sel(nj_imm_sel),
    .result_src(nj_result_src), .reg_write(nj_reg_write), .illegal_instr(nj_illegal_instr),
    .mem_timeout(nj_mem_timeout), .state_o(nj_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control vector for one cycle in state st, written from the state descriptions.
  function automatic logic [23:0] exp_ctl(input logic [3:0] st, input logic [6:0] op,
                                          input logic rdy, input logic ill, input logic to);
    logic req, we, iod, irw, pcw, pcc, rw;
    logic [1:0] sa, sb, aop, rs;
    logic [2:0] imm;
    {req, we, iod, irw, pcw, pcc, rw} = '0;
    {sa, sb, aop, rs} = '0;
    imm = 3'd0;
    case (st)
      S_FETCH:     begin req = 1; sb = 2'd2; irw = rdy; pcw = rdy; end
      S_DECODE:    begin sa = 2'd2; sb = 2'd1; imm = 3'd2; end
      S_MEM_ADDR:  begin sa = 2'd1; sb = 2'd1; imm = (op == 7'b0100011) ? 3'd1 : 3'd0; end
      S_MEM_READ:  begin req = 1; iod = 1; end
      S_MEM_WB:    begin rw = 1; rs = 2'd1; end
      S_MEM_WRITE: begin req = 1; we = 1; iod = 1; end
      S_EXEC_R:    begin sa = 2'd1; aop = 2'b10; end
      S_EXEC_I:    begin sa = 2'd1; sb = 2'd1; aop = 2'b11; end
      S_ALU_WB:    begin rw = 1; end
      S_BRANCH:    begin sa = 2'd1; aop = 2'b01; pcc = 1; end
      S_JAL:       begin rw = 1; rs = 2'd2; pcw = 1; sa = 2'd2; sb = 2'd1; imm = 3'd4; end
      S_JALR:      begin rw = 1; rs = 2'd2; pcw = 1; sa = 2'd1; sb = 2'd1; end
      S_UPPER:     begin imm = 3'd3; sb = 2'd1; sa = (op == 7'b0110111) ? 2'd3 : 2'd2; end
      default:     begin end
    endcase
    return {st, req, we, iod, irw, pcw, pcc, sa, sb, aop, imm, rs, rw, ill, to};
  endfunction

  task automatic check(input string tag, input logic [23:0] actual);
    logic [23:0] want;
    want = exp_q.pop_front();
    tests_run++;
    assert (actual === want) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, actual, want);
    end
  endtask

  // Entered at a falling edge; drives inputs, checks mid-cycle, leaves at the next falling edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic rdy, input logic z);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(exp_ctl(st, opcode, rdy, ill_exp, to_exp));
    #2;
    check(tag, obs);
    @(negedge clk);
  endtask

  task automatic check_nj(input string tag, input logic [3:0] st, input logic ill);
    exp_q.push_back(exp_ctl(st, opcode, mem_ready, ill, 1'b0));
    check(tag, nj_obs);
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b1;
    mem_ready = 1'b0;
    ill_exp   = 1'b0;
    to_exp    = 1'b0;
    #1;
    exp_q.push_back(24'h0);
    check(tag, obs);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 7'd0;
    @(negedge clk);
    do_reset("reset_state");

    // R-type add, memory ready immediately
    opcode = 7'b0110011;
    cyc("add_fetch", S_FETCH, 1, 0);
    cyc("add_decode", S_DECODE, 0, 0);
    cyc("add_exec", S_EXEC_R, 0, 0);
    cyc("add_wb", S_ALU_WB, 0, 0);

    // Load with three wait cycles in both memory states
    opcode = 7'b0000011;
    for (int i = 0; i < 3; i++) cyc("ld_fetch_wait", S_FETCH, 0, 0);
    cyc("ld_fetch_rdy", S_FETCH, 1, 0);
    cyc("ld_decode", S_DECODE, 0, 0);
    cyc("ld_addr", S_MEM_ADDR, 0, 0);
    for (int i = 0; i < 3; i++) cyc("ld_read_wait", S_MEM_READ, 0, 0);
    cyc("ld_read_rdy", S_MEM_READ, 1, 0);
    cyc("ld_wb", S_MEM_WB, 0, 0);

    // Ready arrives exactly on the limit cycle: no trap
    opcode = 7'b0010011;
    for (int i = 0; i < 4; i++) cyc("lim_fetch_wait", S_FETCH, 0, 0);
    cyc("lim_fetch_rdy", S_FETCH, 1, 0);
    cyc("addi_decode", S_DECODE, 0, 0);
    cyc("addi_exec", S_EXEC_I, 0, 0);
    cyc("addi_wb", S_ALU_WB, 0, 0);

    // Branch taken and not taken
    opcode = 7'b1100011;
    cyc("br1_fetch", S_FETCH, 1, 1);
    cyc("br1_decode", S_DECODE, 0, 1);
    cyc("br1_branch", S_BRANCH, 0, 1);
    cyc("br0_fetch", S_FETCH, 1, 0);
    cyc("br0_decode", S_DECODE, 0, 0);
    cyc("br0_branch", S_BRANCH, 0, 0);

    // LUI, AUIPC, JALR
    opcode = 7'b0110111;
    cyc("lui_fetch", S_FETCH, 1, 0);
    cyc("lui_decode", S_DECODE, 0, 0);
    cyc("lui_upper", S_UPPER, 0, 0);
    cyc("lui_wb", S_ALU_WB, 0, 0);
    opcode = 7'b0010111;
    cyc("auipc_fetch", S_FETCH, 1, 0);
    cyc("auipc_decode", S_DECODE, 0, 0);
    cyc("auipc_upper", S_UPPER, 0, 0);
    cyc("auipc_wb", S_ALU_WB, 0, 0);
    opcode = 7'b1100111;
    cyc("jalr_fetch", S_FETCH, 1, 0);
    cyc("jalr_decode", S_DECODE, 0, 0);
    cyc("jalr_exec", S_JALR, 0, 0);

    // Store never acknowledged: trap after the wait limit
    opcode = 7'b0100011;
    cyc("st_fetch", S_FETCH, 1, 0);
    cyc("st_decode", S_DECODE, 0, 0);
    cyc("st_addr", S_MEM_ADDR, 0, 0);
    for (int i = 0; i < 5; i++) cyc("st_write_wait", S_MEM_WRITE, 0, 0);
    to_exp = 1'b1;
    cyc("st_trap", S_TRAP, 0, 0);
    cyc("st_trap_ready_ignored", S_TRAP, 1, 0);
    cyc("st_trap_hold", S_TRAP, 0, 0);
    do_reset("reset_after_timeout");

    // Illegal opcode
    opcode = 7'b1111111;
    cyc("ill_fetch", S_FETCH, 1, 0);
    cyc("ill_decode", S_DECODE, 0, 0);
    ill_exp = 1'b1;
    cyc("ill_trap", S_TRAP, 1, 0);
    cyc("ill_trap_hold", S_TRAP, 0, 0);
    do_reset("reset_after_illegal");

    // JAL: legal on dut, illegal on the jump-disabled instance
    opcode = 7'b1101111;
    cyc("jal_fetch", S_FETCH, 1, 0);
    check_nj("nj_jal_decode", S_DECODE, 1'b0);
    cyc("jal_decode", S_DECODE, 0, 0);
    check_nj("nj_jal_trap", S_TRAP, 1'b1);
    cyc("jal_exec", S_JAL, 0, 0);
    check_nj("nj_jal_trap_hold", S_TRAP, 1'b1);
    cyc("jal_next_fetch", S_FETCH, 1, 0);

    // Reset in the middle of a load's memory read
    opcode = 7'b0000011;
    cyc("rl_decode", S_DECODE, 0, 0);
    cyc("rl_addr", S_MEM_ADDR, 0, 0);
    cyc("rl_read_wait", S_MEM_READ, 0, 0);
    do_reset("reset_mid_read");
    cyc("rl_fetch_after_reset", S_FETCH, 1, 0);
    check_nj("nj_after_reset", S_DECODE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    tests_failed++;
    $display("FAIL watchdog: simulation time limit reached before the sequence completed");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
